// File: rtl/mesm6_pkg.sv
// Shared definitions for the mesm6 memory bus arbiter slice:
// bus widths and the arbiter FSM state encoding.
package mesm6_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // A dbus request is any read or write strobe; write wins when both are set.
  function automatic logic dbus_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mesm6_fetch_buf.sv
// One-word instruction fetch buffer: remembers tag and data of the last
// ibus memory read, and drops it when a dbus write lands on the tagged word.
// Only instantiated when MESM6_ARB_FBUF_EN is defined.
module mesm6_fetch_buf
  import mesm6_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval_en,
  input  logic [ADDR_W-1:0] inval_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              valid_r;
  logic [ADDR_W-1:0] tag_r;
  logic [DATA_W-1:0] data_r;

  assign hit      = valid_r && (tag_r == lookup_addr);
  assign hit_data = data_r;

  // Fill on a completed fetch, invalidate on a write to the buffered word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      tag_r   <= {ADDR_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else if (fill_en) begin
      valid_r <= 1'b1;
      tag_r   <= fill_addr;
      data_r  <= fill_data;
    end else if (inval_en && valid_r && (tag_r == inval_addr)) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/mesm6_membus_arbiter.sv
// Arbitrates the instruction bus (ibus) and data bus (dbus) onto a single
// memory port, one transaction at a time (IDLE -> MEM -> RESP -> IDLE).
// dbus normally wins; after STARVE_LIMIT consecutive dbus grants taken
// while a fetch waits, the fetch is granted next.
// Optional feature: define MESM6_ARB_FBUF_EN to add a one-word fetch buffer
// that answers repeated fetches of the same address without a memory access.
module mesm6_membus_arbiter
  import mesm6_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ibus_fetch,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic [DATA_W-1:0] ibus_input,
  output logic              ibus_done,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_output,
  output logic [DATA_W-1:0] dbus_input,
  output logic              dbus_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_r,      state_nx_s;
  logic [CNT_W-1:0]  starve_cnt_r, starve_nx_s;
  logic              gnt_dbus_r,   gnt_dbus_nx_s;
  logic              mem_req_r,    mem_req_nx_s;
  logic              mem_we_r,     mem_we_nx_s;
  logic [ADDR_W-1:0] mem_addr_r,   mem_addr_nx_s;
  logic [DATA_W-1:0] mem_wdata_r,  mem_wdata_nx_s;
  logic [DATA_W-1:0] data_r,       data_nx_s;
  logic              ibus_done_r,  ibus_done_nx_s;
  logic              dbus_done_r,  dbus_done_nx_s;

  logic              dbus_req_s;
  logic              starved_s;
  logic              fb_hit_s;
  logic [DATA_W-1:0] fb_data_s;

  assign dbus_req_s = dbus_req(dbus_read, dbus_write);
  assign starved_s  = ibus_fetch && (starve_cnt_r >= STARVE_MAX);

`ifdef MESM6_ARB_FBUF_EN
  logic fill_s;
  logic inval_s;

  // A completed ibus access is always a read; a dbus write completion may
  // hit the buffered word and must drop it.
  assign fill_s  = (state_r == ST_MEM) && mem_ack && !gnt_dbus_r;
  assign inval_s = (state_r == ST_MEM) && mem_ack && gnt_dbus_r && mem_we_r;

  mesm6_fetch_buf u_fetch_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .lookup_addr (ibus_addr),
    .fill_en     (fill_s),
    .fill_addr   (mem_addr_r),
    .fill_data   (mem_rdata),
    .inval_en    (inval_s),
    .inval_addr  (mem_addr_r),
    .hit         (fb_hit_s),
    .hit_data    (fb_data_s)
  );
`else
  assign fb_hit_s  = 1'b0;
  assign fb_data_s = {DATA_W{1'b0}};
`endif

  // Next-state, grant decision and next value of every registered output
  always_comb begin
    state_nx_s     = state_r;
    starve_nx_s    = starve_cnt_r;
    gnt_dbus_nx_s  = gnt_dbus_r;
    mem_req_nx_s   = 1'b0;
    mem_we_nx_s    = 1'b0;
    mem_addr_nx_s  = mem_addr_r;
    mem_wdata_nx_s = mem_wdata_r;
    data_nx_s      = data_r;
    ibus_done_nx_s = 1'b0;
    dbus_done_nx_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (dbus_req_s && !starved_s) begin
          state_nx_s     = ST_MEM;
          gnt_dbus_nx_s  = 1'b1;
          mem_req_nx_s   = 1'b1;
          mem_we_nx_s    = dbus_write;
          mem_addr_nx_s  = dbus_addr;
          mem_wdata_nx_s = dbus_output;
          if (ibus_fetch) begin
            starve_nx_s = starve_cnt_r + CNT_W'(1);
          end else begin
            starve_nx_s = {CNT_W{1'b0}};
          end
        end else if (ibus_fetch) begin
          if (fb_hit_s) begin
            // Buffer hit: answer straight away, starvation count untouched
            state_nx_s     = ST_RESP;
            gnt_dbus_nx_s  = 1'b0;
            ibus_done_nx_s = 1'b1;
            data_nx_s      = fb_data_s;
          end else begin
            state_nx_s    = ST_MEM;
            gnt_dbus_nx_s = 1'b0;
            mem_req_nx_s  = 1'b1;
            mem_we_nx_s   = 1'b0;
            mem_addr_nx_s = ibus_addr;
            starve_nx_s   = {CNT_W{1'b0}};
          end
        end else begin
          starve_nx_s = {CNT_W{1'b0}};
        end
      end

      ST_MEM: begin
        if (mem_ack) begin
          state_nx_s     = ST_RESP;
          data_nx_s      = mem_rdata;
          ibus_done_nx_s = !gnt_dbus_r;
          dbus_done_nx_s = gnt_dbus_r;
        end else begin
          mem_req_nx_s = 1'b1;
          mem_we_nx_s  = mem_we_r;
        end
      end

      ST_RESP: begin
        state_nx_s = ST_IDLE;
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    // A fetch that is no longer waiting cannot be starved
    if (!ibus_fetch) begin
      starve_nx_s = {CNT_W{1'b0}};
    end else begin
      starve_nx_s = starve_nx_s;
    end
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      starve_cnt_r <= {CNT_W{1'b0}};
      gnt_dbus_r   <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      data_r       <= {DATA_W{1'b0}};
      ibus_done_r  <= 1'b0;
      dbus_done_r  <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      starve_cnt_r <= starve_nx_s;
      gnt_dbus_r   <= gnt_dbus_nx_s;
      mem_req_r    <= mem_req_nx_s;
      mem_we_r     <= mem_we_nx_s;
      mem_addr_r   <= mem_addr_nx_s;
      mem_wdata_r  <= mem_wdata_nx_s;
      data_r       <= data_nx_s;
      ibus_done_r  <= ibus_done_nx_s;
      dbus_done_r  <= dbus_done_nx_s;
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign ibus_done  = ibus_done_r;
  assign dbus_done  = dbus_done_r;
  assign ibus_input = data_r;
  assign dbus_input = data_r;

endmodule

// File: tb/tb_mesm6_membus_arbiter.sv
// Self-checking bench for mesm6_membus_arbiter: directed scenarios followed
// by randomized traffic, all checked against a cycle-stepped behavioural
// model of the arbitration rules. Define MESM6_ARB_FBUF_EN to also exercise
// the fetch buffer.
module tb_mesm6_membus_arbiter;

  localparam int LIMIT  = 4;
  localparam int P_IDLE = 0;
  localparam int P_MEM  = 1;
  localparam int P_RESP = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ibus_fetch = 1'b0;
  logic [14:0] ibus_addr = 15'd0;
  logic [47:0] ibus_input;
  logic        ibus_done;
  logic        dbus_read = 1'b0;
  logic        dbus_write = 1'b0;
  logic [14:0] dbus_addr = 15'd0;
  logic [47:0] dbus_output = 48'd0;
  logic [47:0] dbus_input;
  logic        dbus_done;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [47:0] mem_wdata;
  logic [47:0] mem_rdata = 48'd0;
  logic        mem_ack = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  // model state
  int          m_phase = P_IDLE;
  int          m_cnt   = 0;
  bit          m_side_d = 1'b0;
  bit          m_we    = 1'b0;
  logic [14:0] m_addr  = 15'd0;
  logic [47:0] m_wdata = 48'd0;
  logic [47:0] m_data  = 48'd0;
  bit          exp_ib  = 1'b0;
  bit          exp_db  = 1'b0;
`ifdef MESM6_ARB_FBUF_EN
  bit          m_fb_valid = 1'b0;
  logic [14:0] m_fb_tag   = 15'd0;
  logic [47:0] m_fb_data  = 48'd0;
`endif

  mesm6_membus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ibus_fetch  (ibus_fetch),
    .ibus_addr   (ibus_addr),
    .ibus_input  (ibus_input),
    .ibus_done   (ibus_done),
    .dbus_read   (dbus_read),
    .dbus_write  (dbus_write),
    .dbus_addr   (dbus_addr),
    .dbus_output (dbus_output),
    .dbus_input  (dbus_input),
    .dbus_done   (dbus_done),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by the edge that just passed, using the input values
  // the DUT sampled at it, then compare every output.
  task automatic model_step();
    exp_ib = 1'b0;
    exp_db = 1'b0;
    if (!reset_n) begin
      m_phase = P_IDLE;
      m_cnt   = 0;
      m_data  = 48'd0;
`ifdef MESM6_ARB_FBUF_EN
      m_fb_valid = 1'b0;
`endif
      check_eq("rst_mem_we", {63'd0, mem_we}, 64'd0);
    end else begin
      case (m_phase)
        P_IDLE: begin
          if ((dbus_read || dbus_write) && !(ibus_fetch && m_cnt >= LIMIT)) begin
            m_phase  = P_MEM;
            m_side_d = 1'b1;
            m_we     = dbus_write;
            m_addr   = dbus_addr;
            m_wdata  = dbus_output;
            m_cnt    = ibus_fetch ? m_cnt + 1 : 0;
          end else if (ibus_fetch) begin
`ifdef MESM6_ARB_FBUF_EN
            if (m_fb_valid && m_fb_tag == ibus_addr) begin
              m_phase = P_RESP;
              m_data  = m_fb_data;
              exp_ib  = 1'b1;
            end else begin
              m_phase  = P_MEM;
              m_side_d = 1'b0;
              m_we     = 1'b0;
              m_addr   = ibus_addr;
              m_cnt    = 0;
            end
`else
            m_phase  = P_MEM;
            m_side_d = 1'b0;
            m_we     = 1'b0;
            m_addr   = ibus_addr;
            m_cnt    = 0;
`endif
          end
        end
        P_MEM: begin
          if (mem_ack) begin
            m_phase = P_RESP;
            m_data  = mem_rdata;
            exp_db  = m_side_d;
            exp_ib  = !m_side_d;
`ifdef MESM6_ARB_FBUF_EN
            if (!m_side_d) begin
              m_fb_valid = 1'b1;
              m_fb_tag   = m_addr;
              m_fb_data  = mem_rdata;
            end else if (m_we && m_fb_tag == m_addr) begin
              m_fb_valid = 1'b0;
            end
`endif
          end
        end
        default: m_phase = P_IDLE;
      endcase
      if (!ibus_fetch) m_cnt = 0;
    end
    check_eq("mem_req", {63'd0, mem_req}, (m_phase == P_MEM) ? 64'd1 : 64'd0);
    if (m_phase == P_MEM) begin
      check_eq("mem_addr", {49'd0, mem_addr}, {49'd0, m_addr});
      check_eq("mem_we", {63'd0, mem_we}, {63'd0, m_we});
      if (m_we) check_eq("mem_wdata", {16'd0, mem_wdata}, {16'd0, m_wdata});
    end
    check_eq("ibus_done", {63'd0, ibus_done}, {63'd0, exp_ib});
    check_eq("dbus_done", {63'd0, dbus_done}, {63'd0, exp_db});
    check_eq("ibus_input", {16'd0, ibus_input}, {16'd0, m_data});
    check_eq("dbus_input", {16'd0, dbus_input}, {16'd0, m_data});
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
  endtask

  function automatic logic [14:0] pick_addr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(3))
      0: return 15'o200;
      1: return 15'o201;
      2: return 15'o202;
      default: return r[14:0];
    endcase
  endfunction

  // Random masters: hold a request until its done, occasionally abandon it
  task automatic drive_random();
    logic [63:0] t;
    int r;
    if (exp_ib) ibus_fetch = 1'b0;
    else if (!ibus_fetch && $urandom_range(3) == 0) begin
      ibus_fetch = 1'b1;
      ibus_addr  = pick_addr();
    end else if (ibus_fetch && $urandom_range(15) == 0) ibus_fetch = 1'b0;

    if (exp_db) begin
      dbus_read  = 1'b0;
      dbus_write = 1'b0;
    end else if (!(dbus_read || dbus_write) && $urandom_range(2) == 0) begin
      r = $urandom_range(3);
      dbus_read  = (r != 1);
      dbus_write = (r == 1 || r == 2);
      dbus_addr  = pick_addr();
      t = {$urandom(), $urandom()};
      dbus_output = t[47:0];
    end else if ((dbus_read || dbus_write) && $urandom_range(15) == 0) begin
      dbus_read  = 1'b0;
      dbus_write = 1'b0;
    end

    t = {$urandom(), $urandom()};
    mem_rdata = t[47:0];
    mem_ack   = ($urandom_range(2) == 0);
    reset_n   = ($urandom_range(199) != 0);
  endtask

  initial begin
    int dcnt, icnt, dbefore, ndone;
    bit prev_req;

    // reset
    repeat (3) tick();
    check_eq("rst_req", {63'd0, mem_req}, 64'd0);
    check_eq("rst_data", {16'd0, dbus_input}, 64'd0);
    reset_n = 1'b1;
    tick();

    // dbus read, ack two cycles after mem_req
    dbus_read = 1'b1; dbus_addr = 15'o100;
    tick();
    check_eq("d26_req", {63'd0, mem_req}, 64'd1);
    check_eq("d26_addr", {49'd0, mem_addr}, 64'o100);
    dbus_read = 1'b0;
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 48'h123456789ABC;
    tick();
    check_eq("d26_done", {63'd0, dbus_done}, 64'd1);
    check_eq("d26_data", {16'd0, dbus_input}, 64'h123456789ABC);
    check_eq("d26_ibus_done", {63'd0, ibus_done}, 64'd0);
    mem_ack = 1'b0;
    tick();
    check_eq("d26_done_drop", {63'd0, dbus_done}, 64'd0);

    // dbus write, ack in first MEM cycle (minimum latency)
    dbus_write = 1'b1; dbus_addr = 15'd5; dbus_output = 48'hFFFF00000000;
    tick();
    check_eq("d27_we", {63'd0, mem_we}, 64'd1);
    check_eq("d27_wdata", {16'd0, mem_wdata}, 64'hFFFF00000000);
    dbus_write = 1'b0; mem_ack = 1'b1;
    tick();
    check_eq("d27_done", {63'd0, dbus_done}, 64'd1);
    mem_ack = 1'b0; ndone = 0;
    repeat (3) begin tick(); ndone += int'(dbus_done); end
    check_eq("d27_no_extra_done", 64'(ndone), 64'd0);

    // starvation: fetch held against back-to-back dbus reads
    ibus_fetch = 1'b1; ibus_addr = 15'o7000;
    dbus_read = 1'b1; dbus_addr = 15'o1000;
    dcnt = 0; icnt = 0; dbefore = -1; prev_req = 1'b0; ndone = 0;
    for (int i = 0; i < 100 && !(ndone == 6 && icnt == 1); i++) begin
      tick();
      if (mem_req && !prev_req) begin
        if (mem_addr == 15'o7000) dbefore = dcnt;
        else dcnt++;
      end
      prev_req = mem_req;
      mem_ack = mem_req;
      if (dbus_done) begin
        ndone++;
        if (ndone == 6) dbus_read = 1'b0;
        else dbus_addr = dbus_addr + 15'd1;
      end
      if (ibus_done) begin icnt++; ibus_fetch = 1'b0; end
    end
    check_eq("d28_dbus_before_ibus", 64'(dbefore), 64'd4);
    check_eq("d28_dbus_done_total", 64'(ndone), 64'd6);
    check_eq("d28_ibus_done_total", 64'(icnt), 64'd1);
    ibus_fetch = 1'b0; dbus_read = 1'b0; mem_ack = 1'b0;
    repeat (2) tick();

    // reset during MEM, then a late ack
    dbus_read = 1'b1; dbus_addr = 15'o300;
    tick();
    check_eq("d29_in_mem", {63'd0, mem_req}, 64'd1);
    dbus_read = 1'b0; reset_n = 1'b0;
    tick();
    check_eq("d29_rst_req", {63'd0, mem_req}, 64'd0);
    reset_n = 1'b1; mem_ack = 1'b1; mem_rdata = 48'hDEADBEEF0001;
    tick();
    check_eq("d29_no_done", {62'd0, ibus_done, dbus_done}, 64'd0);
    mem_ack = 1'b0;
    tick();
    check_eq("d29_idle_req", {63'd0, mem_req}, 64'd0);
    check_eq("d29_data_cleared", {16'd0, dbus_input}, 64'd0);

`ifdef MESM6_ARB_FBUF_EN
    // fetch buffer: repeat fetch hits, dbus write invalidates
    ibus_fetch = 1'b1; ibus_addr = 15'o200;
    tick();
    mem_ack = 1'b1; mem_rdata = 48'hA5A5_0000_1111;
    tick();
    check_eq("d30_fill_done", {63'd0, ibus_done}, 64'd1);
    ibus_fetch = 1'b0; mem_ack = 1'b0;
    tick();
    ibus_fetch = 1'b1;
    tick();
    check_eq("d30_hit_no_req", {63'd0, mem_req}, 64'd0);
    check_eq("d30_hit_done", {63'd0, ibus_done}, 64'd1);
    check_eq("d30_hit_data", {16'd0, ibus_input}, 64'hA5A500001111);
    ibus_fetch = 1'b0;
    tick();
    dbus_write = 1'b1; dbus_addr = 15'o200; dbus_output = 48'h0000_2222_3333;
    tick();
    dbus_write = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    ibus_fetch = 1'b1;
    tick();
    check_eq("d30_miss_req", {63'd0, mem_req}, 64'd1);
    mem_ack = 1'b1;
    tick();
    ibus_fetch = 1'b0; mem_ack = 1'b0;
    repeat (2) tick();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
